// File: rtl/motion_command_sequencer_pkg.sv
// Shared definitions for the motion command sequencer: field offsets, FSM states, symbolic field values.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package motion_defs;

    // Field positions, given as offsets below the top bit of the enclosing field.
    // direction sits at CMD_W-DIR_BIT, command_type at CMD_W-TYPE_BIT,
    // and the curve flag at ANGLE_W-CURVE_BIT.
    localparam int DIR_BIT   = 1;
    localparam int TYPE_BIT  = 2;
    localparam int CURVE_BIT = 1;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    // Symbolic field values.
    localparam logic DIR_FWD      = 1'b0;
    localparam logic DIR_REV      = 1'b1;
    localparam logic CMD_STRAIGHT = 1'b0;
    localparam logic CMD_TURN     = 1'b1;

endpackage

// File: rtl/motion_cmd_fifo.sv
// Circular command buffer with push/pop/flush and occupancy count.
// Latency: a push is visible at the head one cycle later; pop data is combinational from the head.
// Backpressure: full refuses pushes (no bypass on simultaneous pop); flush empties and drops a coincident push.
module motion_cmd_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); flush rewinds both.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy: flush wins over everything, push+pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else if (do_push && !do_pop) begin
            count <= count + CW'(1);
        end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/motion_command_sequencer.sv
// Queues packed motion commands and issues them one at a time with a start/done handshake.
// Latency: command pushed at edge k into an idle, empty sequencer shows exec_start after edge k+1; one bubble after done.
// Backpressure: cmd_in_ready drops while the queue is full. Optional watchdog: MOTION_WATCHDOG_EN.
module motion_command_sequencer
    import motion_defs::*;
#(
    parameter int ANGLE_W     = 8,
    parameter int DEPTH       = 4,
    parameter int WDOG_CYCLES = 1000000,
    localparam int CMD_W      = ANGLE_W + 2,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CMD_W-1:0]   cmd_in,
    input  logic               cmd_in_valid,
    output logic               cmd_in_ready,
    input  logic               flush,
    output logic               exec_start,
    input  logic               exec_done,
    output logic               direction,
    output logic               command_type,
    output logic               curved,
    output logic [ANGLE_W-2:0] angle,
    output logic               busy,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               watchdog_err
);

    state_t           state;
    state_t           state_nxt;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] head_dat;
    logic             wdog_hit;

    motion_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cmd_in_valid),
        .push_dat (cmd_in),
        .pop      (pop),
        .flush    (flush),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign cmd_in_ready = !fifo_full;
    assign exec_start   = (state == ST_ISSUE);
    assign busy         = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and pop request; exec_done matters only in BUSY.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (exec_done || wdog_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Field registers load on pop and hold until the next pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            direction    <= 1'b0;
            command_type <= 1'b0;
            curved       <= 1'b0;
            angle        <= '0;
        end else if (pop) begin
            direction    <= head_dat[CMD_W-DIR_BIT];
            command_type <= head_dat[CMD_W-TYPE_BIT];
            curved       <= head_dat[ANGLE_W-CURVE_BIT];
            angle        <= head_dat[ANGLE_W-2:0];
        end
    end

`ifdef MOTION_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;

    // A done arriving on the limit cycle is a normal completion, not a timeout.
    assign wdog_hit = (state == ST_BUSY) && !exec_done &&
                      (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    // Cycle counter: zero on the first BUSY cycle, counting each BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset || state == ST_ISSUE) begin
            wdog_cnt <= '0;
        end else if (state == ST_BUSY) begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            watchdog_err <= 1'b0;
        end else if (wdog_hit) begin
            watchdog_err <= 1'b1;
        end
    end
`else
    assign wdog_hit     = 1'b0;
    assign watchdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_motion_command_sequencer.sv
// Directed self-checking bench for motion_command_sequencer (ANGLE_W=8, DEPTH=4, WDOG_CYCLES=16).
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: exercised via full-queue, flush and mid-command reset sequences.
module tb_motion_command_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] cmd_in;
    logic       cmd_in_valid;
    logic       cmd_in_ready;
    logic       flush;
    logic       exec_start;
    logic       exec_done;
    logic       direction;
    logic       command_type;
    logic       curved;
    logic [6:0] angle;
    logic       busy;
    logic [2:0] fifo_count;
    logic       watchdog_err;

    int n_cmp = 0;
    int n_bad = 0;

    motion_command_sequencer #(
        .ANGLE_W     (8),
        .DEPTH       (4),
        .WDOG_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_in       (cmd_in),
        .cmd_in_valid (cmd_in_valid),
        .cmd_in_ready (cmd_in_ready),
        .flush        (flush),
        .exec_start   (exec_start),
        .exec_done    (exec_done),
        .direction    (direction),
        .command_type (command_type),
        .curved       (curved),
        .angle        (angle),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .watchdog_err (watchdog_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic       flsh;
        logic       done;
        logic [9:0] cmd;
        logic       e_rdy;
        logic       e_start;
        logic       e_busy;
        logic [9:0] e_fields;
        logic [2:0] e_count;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] fields();
        return {direction, command_type, curved, angle};
    endfunction

    task automatic push_tick(input logic [9:0] c);
        cmd_in       = c;
        cmd_in_valid = 1'b1;
        tick();
        cmd_in_valid = 1'b0;
    endtask

    // Done in BUSY, one bubble cycle, then the next command issues.
    task automatic done_then_issue(input string tag, input logic [9:0] exp, input logic [2:0] exp_cnt);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk({tag, " bubble busy"}, 32'(busy), 32'd0);
        chk({tag, " bubble start"}, 32'(exec_start), 32'd0);
        tick();
        chk({tag, " start"}, 32'(exec_start), 32'd1);
        chk({tag, " fields"}, 32'(fields()), 32'(exp));
        chk({tag, " count"}, 32'(fifo_count), 32'(exp_cnt));
        tick();
        chk({tag, " busy start"}, 32'(exec_start), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cmd_in = '0; cmd_in_valid = 1'b0; flush = 1'b0; exec_done = 1'b0;

        // rst vld flush done cmd | rdy start busy fields count
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 3'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h2A5, 1'b1, 1'b0, 1'b0, 10'h000, 3'd1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 1'b1, 1'b1, 10'h2A5, 3'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h2A5, 3'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b1, 1'b0, 1'b0, 10'h2A5, 3'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h2A5, 3'd0};

        for (int i = 0; i < 6; i++) begin
            reset = vecs[i].rst; cmd_in_valid = vecs[i].vld; flush = vecs[i].flsh;
            exec_done = vecs[i].done; cmd_in = vecs[i].cmd;
            tick();
            chk($sformatf("vec%0d ready", i),  32'(cmd_in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d start", i),  32'(exec_start),   32'(vecs[i].e_start));
            chk($sformatf("vec%0d busy", i),   32'(busy),         32'(vecs[i].e_busy));
            chk($sformatf("vec%0d fields", i), 32'(fields()),     32'(vecs[i].e_fields));
            chk($sformatf("vec%0d count", i),  32'(fifo_count),   32'(vecs[i].e_count));
        end
        cmd_in_valid = 1'b0; exec_done = 1'b0;
        chk("decode dir", 32'(direction), 32'd1);
        chk("decode angle", 32'(angle), 32'h25);

        // Fill the queue behind a busy command; the overflow push is held off.
        push_tick(10'h111);
        chk("fill count1", 32'(fifo_count), 32'd1);
        push_tick(10'h222);
        chk("fill A start", 32'(exec_start), 32'd1);
        chk("fill A fields", 32'(fields()), 32'h111);
        chk("fill push+pop count", 32'(fifo_count), 32'd1);
        push_tick(10'h333);
        push_tick(10'h0C4);
        chk("fill count3", 32'(fifo_count), 32'd3);
        push_tick(10'h3F5);
        chk("fill count4", 32'(fifo_count), 32'd4);
        chk("fill ready low", 32'(cmd_in_ready), 32'd0);
        push_tick(10'h1E6);
        chk("overflow refused", 32'(fifo_count), 32'd4);
        done_then_issue("order B", 10'h222, 3'd3);
        done_then_issue("order C", 10'h333, 3'd2);
        done_then_issue("order D", 10'h0C4, 3'd1);
        done_then_issue("order E", 10'h3F5, 3'd0);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        tick();
        chk("drained no start", 32'(exec_start), 32'd0);
        chk("drained fields hold", 32'(fields()), 32'h3F5);

        // exec_done during ISSUE is ignored.
        push_tick(10'h04A);
        tick();
        chk("ign issue", 32'(exec_start), 32'd1);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("ign busy after", 32'(busy), 32'd1);
        tick();
        chk("ign still busy", 32'(busy), 32'd1);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("ign real done", 32'(busy), 32'd0);

        // Flush during BUSY empties the queue but lets the current command finish.
        push_tick(10'h101);
        push_tick(10'h102);
        push_tick(10'h103);
        push_tick(10'h104);
        chk("flush pre count", 32'(fifo_count), 32'd3);
        flush = 1'b1; cmd_in = 10'h1FF; cmd_in_valid = 1'b1;
        chk("flush ready", 32'(cmd_in_ready), 32'd1);
        tick();
        flush = 1'b0; cmd_in_valid = 1'b0;
        chk("flush count", 32'(fifo_count), 32'd0);
        chk("flush busy kept", 32'(busy), 32'd1);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("flush done", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("flush quiet%0d", i), 32'(exec_start), 32'd0);
        end

        // Flush coinciding with a pop: the popped command still issues.
        push_tick(10'h0AB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flushpop start", 32'(exec_start), 32'd1);
        chk("flushpop fields", 32'(fields()), 32'h0AB);
        chk("flushpop count", 32'(fifo_count), 32'd0);
        tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;

        // Reset mid-command with two queued.
        push_tick(10'h211);
        push_tick(10'h212);
        push_tick(10'h213);
        chk("rst pre busy", 32'(busy), 32'd1);
        chk("rst pre count", 32'(fifo_count), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst start", 32'(exec_start), 32'd0);
        chk("rst fields", 32'(fields()), 32'd0);
        chk("rst count", 32'(fifo_count), 32'd0);
        tick();
        chk("rst after start", 32'(exec_start), 32'd0);

`ifdef MOTION_WATCHDOG_EN
        // Never answer done: 16 BUSY cycles, then forced IDLE and sticky error.
        push_tick(10'h311);
        push_tick(10'h312);
        chk("wd issue", 32'(exec_start), 32'd1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("wd busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("wd err%0d", i), 32'(watchdog_err), 32'd0);
        end
        tick();
        chk("wd idle", 32'(busy), 32'd0);
        chk("wd err set", 32'(watchdog_err), 32'd1);
        tick();
        chk("wd next start", 32'(exec_start), 32'd1);
        chk("wd next fields", 32'(fields()), 32'h312);
        tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("wd sticky", 32'(watchdog_err), 32'd1);
`else
        chk("wd tied low", 32'(watchdog_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/motion_command_sequencer.md
Name: motion_command_sequencer

Overview:
- Parametrised successor to the fixed 10-bit motion-command field splitter.
- Accepts packed motion commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Decodes fields with a configurable angle width and issues one command at a time to the motor controller with a start/done handshake.
- Sits between the command source (navigation/UART decoder) and the drive controller.

Parameters:
- ANGLE_W, 8, angle field width including the curve flag (MSB); must be >= 2.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- WDOG_CYCLES, 1000000, watchdog limit in clk cycles; used only with MOTION_WATCHDOG_EN.
- CMD_W, ANGLE_W+2 (localparam, derived), packed command width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_in  in  CMD_W  packed command: [CMD_W-1]=direction, [CMD_W-2]=command_type, [ANGLE_W-1]=curved, [ANGLE_W-2:0]=angle magnitude.
- cmd_in_valid  in  1  source presents cmd_in.
- cmd_in_ready  out  1  FIFO can accept.
- flush  in  1  discard all queued, not-yet-issued commands.
- exec_start  out  1  one-cycle pulse: the issued fields are valid.
- exec_done  in  1  controller finished the current command.
- direction  out  1  issued direction.
- command_type  out  1  issued command type.
- curved  out  1  issued curve flag.
- angle  out  ANGLE_W-1  issued angle magnitude.
- busy  out  1  a command is issued and not yet done.
- fifo_count  out  $clog2(DEPTH+1)  queued entries.
- watchdog_err  out  1  sticky timeout flag; tied to 0 without the macro.

Behaviour:
- Reset: synchronous, active-high. On reset all outputs go to 0, the FIFO empties, and the FSM enters IDLE. Reset asserted mid-command aborts the command silently, with no exec_start or done side effects.
- Handshake in: a push occurs when cmd_in_valid && cmd_in_ready at a rising edge.
  - cmd_in_ready = !full, registered-free.
  - There is no bypass, so a push is refused when full even if a pop occurs in the same cycle.
- FIFO: circular buffer with log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH.
  - fifo_count increments on a push, decrements on a pop, and is unchanged on a simultaneous push and pop.
- FSM states: IDLE, ISSUE, BUSY.
  - IDLE: if the FIFO is not empty, pop the head at the edge, load the field registers, and go to ISSUE.
  - ISSUE: exec_start=1 for exactly this cycle, busy=1; go to BUSY.
  - BUSY: busy=1. exec_done is sampled only here; on exec_done go to IDLE.
  - exec_done in IDLE or ISSUE is ignored.
- Latency: a command accepted at edge k with an empty FIFO and the FSM in IDLE has its fields valid and exec_start high after edge k+1.
  - exec_done sampled at edge m gives IDLE after m; the next queued command issues after edge m+1 (one bubble cycle).
- Field outputs hold the last issued command until the next pop; they are not cleared on done.
- flush: empties the FIFO at the edge (fifo_count=0). It does not affect an in-flight ISSUE or BUSY command.
  - If flush and a push coincide, flush wins and the push is dropped; cmd_in_ready is still 1 that cycle, and the source is told in the protocol note that flush discards it.
  - If flush and a pop coincide (IDLE with non-empty FIFO), the pop proceeds and the popped command issues.

Optional Feature:
- Macro: MOTION_WATCHDOG_EN.
- With the macro defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches WDOG_CYCLES without exec_done, the FSM forces IDLE and watchdog_err sets.
  - watchdog_err is sticky until reset. Queued commands continue to issue afterwards.
  - exec_done on the same cycle as the limit counts as a normal completion, with no error.
- Without the macro: there is no counter, watchdog_err=0, and BUSY waits indefinitely.

Decomposition:
- Shared package motion_defs holds:
  - field index constants (DIR_BIT, TYPE_BIT, CURVE_BIT offsets relative to CMD_W/ANGLE_W);
  - FSM state encodings;
  - direction and command_type symbolic values (DIR_FWD/DIR_REV, CMD_STRAIGHT/CMD_TURN).
- One sub-module, motion_cmd_fifo, parametrised by width and DEPTH, provides push/pop/full/empty/count.

Test Plan:
- Reset, then push 0x2A5 (ANGLE_W=8) -> after 2 edges exec_start=1 once with direction=1, command_type=0, curved=1, angle=0x25, busy=1.
- Push 5 commands with DEPTH=4 while the first is BUSY -> the 5th is held off; cmd_in_ready=0 when fifo_count=4; the commands issue in order, with one bubble between exec_done and the next exec_start.
- Pulse exec_done during ISSUE -> ignored; busy stays 1 until a BUSY-state exec_done.
- Queue 3 commands and assert flush during BUSY -> fifo_count=0; the current command completes; no further exec_start.
- Assert reset in BUSY with 2 queued -> next cycle all outputs 0, fifo_count=0, no exec_start.
- With MOTION_WATCHDOG_EN and WDOG_CYCLES=16, never send done -> after 16 BUSY cycles watchdog_err=1 (sticky), FSM IDLE, and the next queued command issues.
